ram_reader: RTL and testbench

Read-side engine for the team's synchronous single-port RAM. It accepts read requests over a valid/ready handshake and drives the RAM read strobe and address. It captures read data after a fixed RAM latency and returns address/data pairs over a second valid/ready handshake. A small response FIFO and credit counting guarantee that no returned data is ever dropped under consumer backpressure. It is the counterpart of the existing write-capture path: the write side latches address on `we`, and this block reads back.

---
 rtl/ram_reader_pkg.sv | 21 ++
 rtl/ram_reader_fifo.sv | 65 ++++++
 rtl/ram_reader.sv | 151 +++++++++++++++
 tb/tb_ram_reader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// Shared constants and the response entry layout for the ram_reader read engine.
// The stamp field exists only when RAM_READER_STAMP_EN is defined.
package ram_reader_pkg;

    localparam int RD_LAT_MAX = 4;
    localparam int DEPTH_MAX  = 16;
    localparam int STAMP_W    = 32;

    // Entry layout at the default 8-bit address/data geometry.
    localparam int ENTRY_AW = 8;
    localparam int ENTRY_DW = 8;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [ENTRY_DW-1:0] data;
`ifdef RAM_READER_STAMP_EN
        logic [STAMP_W-1:0]  stamp;
`endif
    } rsp_entry_t;

endpackage

// File: rtl/ram_reader_fifo.sv
// First-word-fall-through response FIFO with a registered occupancy count.
// Pointers carry one extra wrap bit to tell full from empty.
module ram_reader_fifo
    import ram_reader_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic [4:0]   count_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [4:0]    count_q;
    logic [4:0]    count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign rdata_o   = mem_q[rd_ptr_q[PW-2:0]];
    assign count_o   = count_q;

    always_comb begin
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q[PW-2:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ram_reader.sv
// Read-side engine: issues RAM reads under credit control and returns {addr, data}
// in request order. Define RAM_READER_STAMP_EN to add the rsp_stamp port.
module ram_reader
    import ram_reader_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data
`ifdef RAM_READER_STAMP_EN
    ,
    output logic [STAMP_W-1:0] rsp_stamp
`endif
);
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("ram_reader: RD_LAT must be 1..%0d", RD_LAT_MAX);
    end
    if (DEPTH < 2 || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ram_reader: DEPTH must be a power of 2 in 2..%0d", DEPTH_MAX);
    end

    typedef struct packed {
        logic [AW-1:0]      addr;
        logic [DW-1:0]      data;
`ifdef RAM_READER_STAMP_EN
        logic [STAMP_W-1:0] stamp;
`endif
    } entry_t;

    logic              acc_s;
    logic              push_s;
    logic              pop_s;
    logic              empty_s;
    logic              full_s;
    logic [4:0]        fifo_count_s;
    logic [2:0]        inflight_q;
    logic [2:0]        inflight_d;
    logic [RD_LAT-1:0] pipe_vld_q;
    logic [AW-1:0]     pipe_addr_q [RD_LAT];
    entry_t            push_entry_s;
    entry_t            head_s;
`ifdef RAM_READER_STAMP_EN
    logic [STAMP_W-1:0] cycle_q;
    logic [STAMP_W-1:0] pipe_stamp_q [RD_LAT];
`endif

    // Credit covers reads still in the RAM pipe plus entries already queued.
    assign req_ready  = ~rst & (({3'b000, inflight_q} + {1'b0, fifo_count_s}) < 6'(DEPTH));
    assign acc_s      = req_valid & req_ready;
    assign ram_re     = acc_s;
    assign ram_addr   = req_addr;
    assign push_s     = pipe_vld_q[RD_LAT-1];
    assign pop_s      = rsp_valid & rsp_ready;
    assign inflight_d = inflight_q + {2'b00, acc_s} - {2'b00, push_s};

    always_comb begin
        push_entry_s.addr  = pipe_addr_q[RD_LAT-1];
        push_entry_s.data  = ram_rdata;
`ifdef RAM_READER_STAMP_EN
        push_entry_s.stamp = pipe_stamp_q[RD_LAT-1];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 3'd0;
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr_q[i] <= '0;
`ifdef RAM_READER_STAMP_EN
                pipe_stamp_q[i] <= '0;
`endif
            end
        end else begin
            inflight_q <= inflight_d;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
`ifdef RAM_READER_STAMP_EN
                pipe_stamp_q[i] <= pipe_stamp_q[i-1];
`endif
            end
            pipe_vld_q[0]  <= acc_s;
            pipe_addr_q[0] <= req_addr;
`ifdef RAM_READER_STAMP_EN
            pipe_stamp_q[0] <= cycle_q;
`endif
        end
    end

`ifdef RAM_READER_STAMP_EN
    // Free-running cycle counter sampled into each accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end
`endif

    ram_reader_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_s),
        .wdata_i (push_entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .count_o (fifo_count_s),
        .empty_o (empty_s),
        .full_o  (full_s)
    );

    // Response outputs are forced low while reset is asserted.
    always_comb begin
        if (rst) begin
            rsp_valid = 1'b0;
            rsp_addr  = '0;
            rsp_data  = '0;
`ifdef RAM_READER_STAMP_EN
            rsp_stamp = '0;
`endif
        end else begin
            rsp_valid = ~empty_s;
            rsp_addr  = head_s.addr;
            rsp_data  = head_s.data;
`ifdef RAM_READER_STAMP_EN
            rsp_stamp = head_s.stamp;
`endif
        end
    end

    a_no_push_on_full: assert property (@(posedge clk) disable iff (rst) !(push_s && full_s));

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader (RD_LAT=2, DEPTH=4) with a latency-accurate RAM model.
// Stamp checks are compiled in when RAM_READER_STAMP_EN is defined.
module tb_ram_reader;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;
    localparam int LAT    = RD_LAT + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
`ifdef RAM_READER_STAMP_EN
    logic [31:0]   rsp_stamp;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int acc    = 0;

    always #5 clk = ~clk;

    ram_reader #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data)
`ifdef RAM_READER_STAMP_EN
        ,
        .rsp_stamp (rsp_stamp)
`endif
    );

    // RAM model: data appears RD_LAT cycles after the strobe, 0xEE otherwise.
    logic [RD_LAT-1:0] m_vld = '0;
    logic [AW-1:0]     m_addr [RD_LAT];

    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        return a ^ 8'hA0;
    endfunction

    always @(posedge clk) begin
        m_vld[0]  <= ram_re;
        m_addr[0] <= ram_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            m_vld[i]  <= m_vld[i-1];
            m_addr[i] <= m_addr[i-1];
        end
    end

    assign ram_rdata = m_vld[RD_LAT-1] ? ram_val(m_addr[RD_LAT-1]) : 8'hEE;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [AW-1:0] a, input logic rr);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        #1;
    endtask

    task automatic exp_rsp(input string tag, input logic v, input logic [AW-1:0] a);
        check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        if (v) begin
            check({tag, ".addr"}, 32'(rsp_addr), 32'(a));
            check({tag, ".data"}, 32'(rsp_data), 32'(ram_val(a)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;

        // Reset: outputs low even with a request and a ready consumer.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 8'h77, 1'b1);
            check("rst.req_ready", 32'(req_ready), 32'd0);
            check("rst.ram_re",    32'(ram_re),    32'd0);
            check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst.rsp_addr",  32'(rsp_addr),  32'd0);
            check("rst.rsp_data",  32'(rsp_data),  32'd0);
        end

        // Single read of 0x05, held under backpressure, then popped.
        drive(1'b0, 1'b1, 8'h05, 1'b0);
        check("t1.ready_after_rst", 32'(req_ready), 32'd1);
        check("t1.ram_re",          32'(ram_re),    32'd1);
        check("t1.ram_addr",        32'(ram_addr),  32'h05);
        for (int k = 1; k <= LAT + 1; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            check("t1.ram_re_low", 32'(ram_re), 32'd0);
            exp_rsp("t1.rsp", k >= LAT, 8'h05);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        exp_rsp("t1.pop", 1'b1, 8'h05);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        exp_rsp("t1.after_pop", 1'b0, 8'h00);

        // Eight back-to-back reads with the consumer always ready.
        for (int c = 0; c < 8 + LAT + 2; c++) begin
            drive(1'b0, c < 8, AW'(c), 1'b1);
            if (c < 8) check("t2.req_ready", 32'(req_ready), 32'd1);
            exp_rsp("t2.rsp", (c >= LAT) && (c < 8 + LAT), AW'(c - LAT));
        end

        // Consumer stalled: credit admits exactly DEPTH reads.
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b1, AW'(8'h10 + acc), 1'b0);
            check("t3.req_ready", 32'(req_ready), 32'(c < DEPTH));
            if (req_ready) acc++;
        end
        check("t3.accepts", 32'(acc), 32'(DEPTH));
        exp_rsp("t3.head", 1'b1, 8'h10);

        // Release: one pop per cycle, credit returns one cycle after the first pop.
        for (int j = 0; j < 12; j++) begin
            drive(1'b0, j < 8, AW'(8'h10 + acc), 1'b1);
            if (j < 8) check("t4.req_ready", 32'(req_ready), 32'(j != 0));
            if (req_valid && req_ready) acc++;
            exp_rsp("t4.rsp", j <= 10, AW'(8'h10 + j));
        end
        check("t4.accepts", 32'(acc), 32'd11);

        // Reset with two reads in flight; then reads at cycles 10 and 13 after reset.
        drive(1'b0, 1'b1, 8'h30, 1'b1);
        check("t5.ram_re_a", 32'(ram_re), 32'd1);
        drive(1'b0, 1'b1, 8'h31, 1'b1);
        check("t5.ram_re_b", 32'(ram_re), 32'd1);
        drive(1'b1, 1'b1, 8'h55, 1'b1);
        check("t5.rst.req_ready", 32'(req_ready), 32'd0);
        check("t5.rst.ram_re",    32'(ram_re),    32'd0);
        check("t5.rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5.rst.rsp_addr",  32'(rsp_addr),  32'd0);
        check("t5.rst.rsp_data",  32'(rsp_data),  32'd0);
        for (int t = 0; t < 18; t++) begin
            drive(1'b0, (t == 10) || (t == 13), (t == 10) ? 8'h42 : 8'h43, 1'b1);
            if (t == 0) check("t5.ready_after_rst", 32'(req_ready), 32'd1);
            exp_rsp("t5.rsp", (t == 13) || (t == 16), (t == 13) ? 8'h42 : 8'h43);
`ifdef RAM_READER_STAMP_EN
            if (t == 13) check("t5.stamp_a", rsp_stamp, 32'd10);
            if (t == 16) check("t5.stamp_b", rsp_stamp, 32'd13);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
